// File: rtl/cordic_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative CORDIC core among NREQ requesters.
// Optional WAIT-state watchdog enabled with `define CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 18,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*W-1:0]        req_x0,
    input  logic [NREQ*W-1:0]        req_y0,
    input  logic [NREQ*W-1:0]        req_z0,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          res_valid,
    output logic [W-1:0]             res_x,
    output logic [W-1:0]             res_y,
    output logic [W-1:0]             res_z,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic                     busy,
    output logic                     err,
    output logic                     core_start,
    output logic [W-1:0]             core_x0,
    output logic [W-1:0]             core_y0,
    output logic [W-1:0]             core_z0,
    input  logic                     core_done,
    input  logic [W-1:0]             core_xn,
    input  logic [W-1:0]             core_yn,
    input  logic [W-1:0]             core_zn
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [IW-1:0]   ptr_r;
    logic [IW-1:0]   owner_r;
    logic [IW-1:0]   win_s;
    logic            found_s;
    logic            grant_s;
    logic            finish_s;
    logic            tout_s;
    logic            tmo_s;

    // First set request bit after p, wrapping; MSB of the result flags a hit.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
        logic [IW:0]   res;
        logic [IW-1:0] iv;
        int            idx;
        res = {1'b0, p};
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(p) + k) % NREQ;
            iv  = IW'(idx);
            if (r[iv]) begin
                res = {1'b1, iv};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_r;
    logic          err_r;

    assign tmo_s = (state_r == WAIT) && (cnt_r == CW'(TIMEOUT - 1));
    assign err   = err_r;

    // WAIT-cycle counter, cleared on every grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
            err_r <= 1'b0;
        end else begin
            err_r <= tout_s;
            if (grant_s) begin
                cnt_r <= {CW{1'b0}};
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end
`else
    assign tmo_s = 1'b0;
    assign err   = 1'b0;
`endif

    // Arbitration and next-state decode; core_done is masked in the start cycle.
    always_comb begin
        state_s  = state_r;
        grant_s  = 1'b0;
        finish_s = 1'b0;
        tout_s   = 1'b0;
        {found_s, win_s} = rr_pick(req, ptr_r);
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    grant_s = 1'b1;
                    state_s = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (core_done && !core_start) begin
                    finish_s = 1'b1;
                    state_s  = IDLE;
                end else if (tmo_s) begin
                    tout_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant side: operand capture, pointer/owner update and strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r      <= IW'(NREQ - 1);
            owner_r    <= {IW{1'b0}};
            gnt        <= {NREQ{1'b0}};
            core_start <= 1'b0;
            core_x0    <= {W{1'b0}};
            core_y0    <= {W{1'b0}};
            core_z0    <= {W{1'b0}};
        end else begin
            core_start <= grant_s;
            if (grant_s) begin
                gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << win_s;
                ptr_r   <= win_s;
                owner_r <= win_s;
                core_x0 <= req_x0[win_s*W +: W];
                core_y0 <= req_y0[win_s*W +: W];
                core_z0 <= req_z0[win_s*W +: W];
            end else begin
                gnt <= {NREQ{1'b0}};
            end
        end
    end

    // Result side: results are held until the next completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid <= {NREQ{1'b0}};
            res_x     <= {W{1'b0}};
            res_y     <= {W{1'b0}};
            res_z     <= {W{1'b0}};
            res_id    <= {IW{1'b0}};
            busy      <= 1'b0;
        end else begin
            busy <= (state_s == WAIT) | finish_s | tout_s;
            if (finish_s) begin
                res_valid <= {{(NREQ-1){1'b0}}, 1'b1} << owner_r;
                res_x     <= core_xn;
                res_y     <= core_yn;
                res_z     <= core_zn;
                res_id    <= owner_r;
            end else begin
                res_valid <= {NREQ{1'b0}};
                if (tout_s) begin
                    res_id <= owner_r;
                end else begin
                    res_id <= res_id;
                end
            end
        end
    end

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Round-robin arbiter and sequencer that shares one iterative `cordic_top` core among `NREQ` independent requesters, such as several oscillator or phase-rotation channels. It accepts operand sets through a per-requester req/gnt handshake and drives the core's start pulse. It waits for the core's done pulse, then returns the result to the owning requester with a one-cycle valid strobe. It sits between the channel controllers and a single CORDIC instance, replacing a dedicated core per channel.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `W`, 18: operand/result width, matching the CORDIC core.
- `TIMEOUT`, 64: max WAIT cycles before abort; used only with the macro.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req` in NREQ: request per requester; level.
- `req_x0`, `req_y0`, `req_z0` in NREQ*W each: packed operands; requester i occupies bits [i*W +: W].
- `gnt` out NREQ: one-hot, one-cycle pulse; operands of that requester captured.
- `res_valid` out NREQ: one-hot, one-cycle pulse; `res_x/y/z` belong to that requester.
- `res_x`, `res_y`, `res_z` out W: registered result, shared by all requesters.
- `res_id` out clog2(NREQ): owner index; valid with `res_valid` or `err`.
- `busy` out 1: high when not IDLE.
- `err` out 1: one-cycle timeout pulse; tied 0 without the macro.
- `core_start` out 1: one-cycle start to the core.
- `core_x0`, `core_y0`, `core_z0` out W: registered operands to the core, stable from `core_start` until the next grant.
- `core_done` in 1: core completion pulse.
- `core_xn`, `core_yn`, `core_zn` in W: core results, sampled on `core_done`.

## Operation
- States: IDLE and WAIT.
- IDLE:
  - No `req` bit set: stay in IDLE.
  - Otherwise select the winner i = first set `req` bit scanning from `ptr+1` upward, wrapping modulo NREQ.
  - At the next edge: register operands of i to `core_*0`; pulse `gnt[i]` and `core_start` together; set `ptr` to i; set the owner to i; enter WAIT.
- WAIT:
  - Ignore `core_done` in the cycle where `core_start` is high.
  - On `core_done`: at the next edge register `core_xn/yn/zn` to `res_*`; pulse `res_valid[owner]`; drive `res_id` = owner; return to IDLE.
- `ptr` resets to NREQ-1, so requester 0 has first priority after reset. The winner becomes lowest priority on the next arbitration.
- `req` is sampled only in IDLE:
  - A requester keeping `req` high gets back-to-back service, subject to round-robin fairness.
  - A requester wanting one job deasserts `req` in the cycle after `gnt`.
- Operands are passed through unchanged. No arithmetic, no width conversion.
- `core_done` received in IDLE is ignored: no strobe, no state change.
- `res_*` hold their last value until the next result. They are not cleared after a valid strobe.

## Timing
- Reset values (asserted asynchronously): state IDLE; `ptr`=NREQ-1; all outputs 0, including `core_*0`, `res_*`, `res_id`, `busy`, `err`, `gnt`, `res_valid`, `core_start`.
- Latency, with `req` seen in IDLE at cycle 0 and core latency L ≥ 1:
  - `gnt`/`core_start` at cycle 1.
  - `core_done` at cycle 1+L.
  - `res_valid` at cycle 2+L.
  - Earliest next grant at cycle 3+L.
- `busy` is high from cycle 1 through the `res_valid` cycle.
- Reset mid-WAIT aborts the job. No `res_valid` is issued for it. A late `core_done` after reset is ignored.
- Simultaneous requests: exactly one `gnt` bit is set per grant; the others keep waiting.

## Configuration
- `CORDIC_ARB_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT, cleared on entry.
  - If `core_done` has not arrived after TIMEOUT cycles: pulse `err` one cycle, set `res_id` = owner, suppress `res_valid`, leave `res_*` unchanged, return to IDLE.
  - A `core_done` arriving in the same cycle as the timeout wins; no `err` is raised.
- `CORDIC_ARB_TIMEOUT_EN` undefined:
  - No counter. WAIT lasts indefinitely until `core_done` or reset.
  - `err` is constant 0.

## Test plan
- Single job, core model L=18: `req[2]` held for one job with x0=50000, y0=0, z0=100 → `gnt[2]` and `core_start` at cycle 1 with `core_z0`=100; `res_valid[2]` at cycle 20 with `res_*`=model output; `res_id`=2.
- Contention: all `req` bits held high from reset, NREQ=4 → grants in order 0,1,2,3,0, exactly one `gnt` bit per grant; grant spacing L+2 cycles.
- Fairness: `req[1]` and `req[3]` held high → grants alternate 1,3,1,3; requester 1 is never granted twice in a row.
- Stray done: `core_done` pulsed in IDLE → no `res_valid`, `busy` stays 0, state unchanged.
- Reset in WAIT: `rst` low 3 cycles into WAIT, then high; core `done` arrives afterwards → all outputs 0, no `res_valid`; a new `req[0]` is granted normally.
- Timeout, macro on, TIMEOUT=64, core never responds, `req[1]` → `err` pulses 64 cycles after `gnt[1]` with `res_id`=1; `busy` drops; no `res_valid`.
